// File: rtl/diff_commit_stage_if.sv
// Commit-side bundle between the core's commit stage and the difftest collection stage.
// The master side drives retiring-instruction/exception/load/store events; the slave side returns bridge-width records.
interface diff_commit_stage_if;
   logic        c0_valid,       c1_valid;
   logic [31:0] c0_pc,          c1_pc;
   logic [31:0] c0_instr,       c1_instr;
   logic        c0_wen,         c1_wen;
   logic [4:0]  c0_wdest,       c1_wdest;
   logic [31:0] c0_wdata,       c1_wdata;
   logic        c0_mem_en,      c1_mem_en;
   logic [31:0] c0_mem_paddr,   c1_mem_paddr;
   logic        c0_is_cnt,      c1_is_cnt;
   logic        c0_csr_rstat,   c1_csr_rstat;
   logic [31:0] c0_csr_data,    c1_csr_data;
   logic        c0_is_tlbfill,  c1_is_tlbfill;
   logic [4:0]  c0_tlbfill_idx, c1_tlbfill_idx;
   logic [63:0] stable_cnt;
   logic        ex_valid, ex_eret;
   logic [10:0] ex_intrno;
   logic [5:0]  ex_ecode;
   logic [31:0] ex_pc, ex_inst;
   logic [7:0]  st_valid, ld_valid;
   logic [31:0] st_paddr, st_vaddr, st_data, ld_paddr, ld_vaddr;

   logic        o0_valid,       o1_valid;
   logic [63:0] o0_pc,          o1_pc;
   logic [31:0] o0_instr,       o1_instr;
   logic        o0_skip,        o1_skip;
   logic        o0_is_tlbfill,  o1_is_tlbfill;
   logic [4:0]  o0_tlbfill_idx, o1_tlbfill_idx;
   logic        o0_is_cnt,      o1_is_cnt;
   logic [63:0] o0_timer,       o1_timer;
   logic        o0_wen,         o1_wen;
   logic [7:0]  o0_wdest,       o1_wdest;
   logic [63:0] o0_wdata,       o1_wdata;
   logic        o0_csr_rstat,   o1_csr_rstat;
   logic [31:0] o0_csr_data,    o1_csr_data;
   logic        oex_excp_valid, oex_eret;
   logic [10:0] oex_intrNo;
   logic [5:0]  oex_cause;
   logic [31:0] oex_exceptionPC, oex_exceptionInst;
   logic [7:0]  ost_valid, old_valid;
   logic [63:0] ost_paddr, ost_vaddr, ost_data, old_paddr, old_vaddr;
   logic [63:0] commit_cnt;
   logic        timeout;

   modport master (
      output c0_valid, c0_pc, c0_instr, c0_wen, c0_wdest, c0_wdata, c0_mem_en, c0_mem_paddr,
             c0_is_cnt, c0_csr_rstat, c0_csr_data, c0_is_tlbfill, c0_tlbfill_idx,
             c1_valid, c1_pc, c1_instr, c1_wen, c1_wdest, c1_wdata, c1_mem_en, c1_mem_paddr,
             c1_is_cnt, c1_csr_rstat, c1_csr_data, c1_is_tlbfill, c1_tlbfill_idx,
             stable_cnt, ex_valid, ex_eret, ex_intrno, ex_ecode, ex_pc, ex_inst,
             st_valid, st_paddr, st_vaddr, st_data, ld_valid, ld_paddr, ld_vaddr,
      input  o0_valid, o0_pc, o0_instr, o0_skip, o0_is_tlbfill, o0_tlbfill_idx, o0_is_cnt,
             o0_timer, o0_wen, o0_wdest, o0_wdata, o0_csr_rstat, o0_csr_data,
             o1_valid, o1_pc, o1_instr, o1_skip, o1_is_tlbfill, o1_tlbfill_idx, o1_is_cnt,
             o1_timer, o1_wen, o1_wdest, o1_wdata, o1_csr_rstat, o1_csr_data,
             oex_excp_valid, oex_eret, oex_intrNo, oex_cause, oex_exceptionPC, oex_exceptionInst,
             ost_valid, ost_paddr, ost_vaddr, ost_data, old_valid, old_paddr, old_vaddr,
             commit_cnt, timeout
   );

   modport slave (
      input  c0_valid, c0_pc, c0_instr, c0_wen, c0_wdest, c0_wdata, c0_mem_en, c0_mem_paddr,
             c0_is_cnt, c0_csr_rstat, c0_csr_data, c0_is_tlbfill, c0_tlbfill_idx,
             c1_valid, c1_pc, c1_instr, c1_wen, c1_wdest, c1_wdata, c1_mem_en, c1_mem_paddr,
             c1_is_cnt, c1_csr_rstat, c1_csr_data, c1_is_tlbfill, c1_tlbfill_idx,
             stable_cnt, ex_valid, ex_eret, ex_intrno, ex_ecode, ex_pc, ex_inst,
             st_valid, st_paddr, st_vaddr, st_data, ld_valid, ld_paddr, ld_vaddr,
      output o0_valid, o0_pc, o0_instr, o0_skip, o0_is_tlbfill, o0_tlbfill_idx, o0_is_cnt,
             o0_timer, o0_wen, o0_wdest, o0_wdata, o0_csr_rstat, o0_csr_data,
             o1_valid, o1_pc, o1_instr, o1_skip, o1_is_tlbfill, o1_tlbfill_idx, o1_is_cnt,
             o1_timer, o1_wen, o1_wdest, o1_wdata, o1_csr_rstat, o1_csr_data,
             oex_excp_valid, oex_eret, oex_intrNo, oex_cause, oex_exceptionPC, oex_exceptionInst,
             ost_valid, ost_paddr, ost_vaddr, ost_data, old_valid, old_paddr, old_vaddr,
             commit_cnt, timeout
   );
endinterface

// File: rtl/diff_commit_stage.sv
// Registered collection stage feeding the difftest bridge: compacts two commit lanes,
// widens fields to bridge widths, and tracks committed-instruction count plus a no-commit watchdog.
module diff_commit_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 5000,
   parameter logic [31:0] MMIO_BASE      = 32'hBF00_0000,
   parameter logic [31:0] MMIO_MASK      = 32'hFF00_0000
) (
   input logic                clock,
   input logic                resetn,
   diff_commit_stage_if.slave bus
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        wen;
      logic [4:0]  wdest;
      logic [31:0] wdata;
      logic        mem_en;
      logic [31:0] mem_paddr;
      logic        is_cnt;
      logic        csr_rstat;
      logic [31:0] csr_data;
      logic        is_tlbfill;
      logic [4:0]  tlbfill_idx;
   } lane_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] instr;
      logic        skip;
      logic        is_tlbfill;
      logic [4:0]  tlbfill_idx;
      logic        is_cnt;
      logic [63:0] timer;
      logic        wen;
      logic [7:0]  wdest;
      logic [63:0] wdata;
      logic        csr_rstat;
      logic [31:0] csr_data;
   } slot_t;

   typedef struct packed {
      logic        excp_valid;
      logic        eret;
      logic [10:0] intrno;
      logic [5:0]  cause;
      logic [31:0] pc;
      logic [31:0] inst;
   } ex_t;

   typedef struct packed {
      logic [7:0]  valid;
      logic [63:0] paddr;
      logic [63:0] vaddr;
      logic [63:0] data;
   } mem_t;

   localparam int unsigned       IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

   lane_t             lane [2];
   slot_t             slot_d [2];
   slot_t             slot_q [2];
   ex_t               ex_d, ex_q;
   mem_t              st_d, st_q, ld_d, ld_q;
   logic [63:0]       commit_cnt_q;
   logic [IDLE_W-1:0] idle_d, idle_q;
   logic              timeout_q;
   logic              activity;

   // A slot that carries no instruction is driven all-zero so the bridge never sees stale fields.
   function automatic slot_t widen(input lane_t l, input logic [63:0] stable);
      slot_t s;
      s = '0;
      if (l.valid) begin
         s.valid       = 1'b1;
         s.pc          = {32'b0, l.pc};
         s.instr       = l.instr;
         s.skip        = l.mem_en && ((l.mem_paddr & MMIO_MASK) == MMIO_BASE);
         s.is_tlbfill  = l.is_tlbfill;
         s.tlbfill_idx = l.tlbfill_idx;
         s.is_cnt      = l.is_cnt;
         s.timer       = l.is_cnt ? stable : 64'b0;
         s.wen         = l.wen && (l.wdest != 5'd0);
         s.wdest       = {3'b0, l.wdest};
         s.wdata       = {32'b0, l.wdata};
         s.csr_rstat   = l.csr_rstat;
         s.csr_data    = l.csr_data;
      end
      return s;
   endfunction

   always_comb begin
      lane[0] = '{valid: bus.c0_valid, pc: bus.c0_pc, instr: bus.c0_instr, wen: bus.c0_wen,
                  wdest: bus.c0_wdest, wdata: bus.c0_wdata, mem_en: bus.c0_mem_en,
                  mem_paddr: bus.c0_mem_paddr, is_cnt: bus.c0_is_cnt, csr_rstat: bus.c0_csr_rstat,
                  csr_data: bus.c0_csr_data, is_tlbfill: bus.c0_is_tlbfill,
                  tlbfill_idx: bus.c0_tlbfill_idx};
      lane[1] = '{valid: bus.c1_valid, pc: bus.c1_pc, instr: bus.c1_instr, wen: bus.c1_wen,
                  wdest: bus.c1_wdest, wdata: bus.c1_wdata, mem_en: bus.c1_mem_en,
                  mem_paddr: bus.c1_mem_paddr, is_cnt: bus.c1_is_cnt, csr_rstat: bus.c1_csr_rstat,
                  csr_data: bus.c1_csr_data, is_tlbfill: bus.c1_is_tlbfill,
                  tlbfill_idx: bus.c1_tlbfill_idx};
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every bit; otherwise a latch is inferred.
      slot_d[0] = '0;
      slot_d[1] = '0;
      if (lane[0].valid) begin
         slot_d[0] = widen(lane[0], bus.stable_cnt);
         slot_d[1] = widen(lane[1], bus.stable_cnt);
      end else begin
         slot_d[0] = widen(lane[1], bus.stable_cnt);
      end
   end

   always_comb begin
      ex_d            = '0;
      ex_d.excp_valid = bus.ex_valid;
      ex_d.eret       = bus.ex_eret;
      if (bus.ex_valid || bus.ex_eret) begin
         ex_d.intrno = bus.ex_intrno;
         ex_d.cause  = bus.ex_ecode;
         ex_d.pc     = bus.ex_pc;
         ex_d.inst   = bus.ex_inst;
      end
   end

   always_comb begin
      st_d       = '0;
      ld_d       = '0;
      st_d.valid = bus.st_valid;
      ld_d.valid = bus.ld_valid;
      if (bus.st_valid != 8'd0) begin
         st_d.paddr = {32'b0, bus.st_paddr};
         st_d.vaddr = {32'b0, bus.st_vaddr};
         st_d.data  = {32'b0, bus.st_data};
      end
      if (bus.ld_valid != 8'd0) begin
         ld_d.paddr = {32'b0, bus.ld_paddr};
         ld_d.vaddr = {32'b0, bus.ld_vaddr};
      end
   end

   // Exceptions count as forward progress for the watchdog; the counter saturates at the limit.
   assign activity = bus.c0_valid | bus.c1_valid | bus.ex_valid | bus.ex_eret;

   always_comb begin
      idle_d = idle_q;
      if (activity)                idle_d = '0;
      else if (idle_q != IDLE_LIMIT) idle_d = idle_q + IDLE_W'(1);
   end

   // NOTE: state registers use non-blocking assignment so all of them sample pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         slot_q[0]    <= '0;
         slot_q[1]    <= '0;
         ex_q         <= '0;
         st_q         <= '0;
         ld_q         <= '0;
         commit_cnt_q <= '0;
         idle_q       <= '0;
         timeout_q    <= 1'b0;
      end else begin
         slot_q[0]    <= slot_d[0];
         slot_q[1]    <= slot_d[1];
         ex_q         <= ex_d;
         st_q         <= st_d;
         ld_q         <= ld_d;
         commit_cnt_q <= commit_cnt_q + 64'(bus.c0_valid) + 64'(bus.c1_valid);
         idle_q       <= idle_d;
         timeout_q    <= timeout_q | (idle_d == IDLE_LIMIT);
      end
   end

   assign bus.o0_valid       = slot_q[0].valid;
   assign bus.o0_pc          = slot_q[0].pc;
   assign bus.o0_instr       = slot_q[0].instr;
   assign bus.o0_skip        = slot_q[0].skip;
   assign bus.o0_is_tlbfill  = slot_q[0].is_tlbfill;
   assign bus.o0_tlbfill_idx = slot_q[0].tlbfill_idx;
   assign bus.o0_is_cnt      = slot_q[0].is_cnt;
   assign bus.o0_timer       = slot_q[0].timer;
   assign bus.o0_wen         = slot_q[0].wen;
   assign bus.o0_wdest       = slot_q[0].wdest;
   assign bus.o0_wdata       = slot_q[0].wdata;
   assign bus.o0_csr_rstat   = slot_q[0].csr_rstat;
   assign bus.o0_csr_data    = slot_q[0].csr_data;

   assign bus.o1_valid       = slot_q[1].valid;
   assign bus.o1_pc          = slot_q[1].pc;
   assign bus.o1_instr       = slot_q[1].instr;
   assign bus.o1_skip        = slot_q[1].skip;
   assign bus.o1_is_tlbfill  = slot_q[1].is_tlbfill;
   assign bus.o1_tlbfill_idx = slot_q[1].tlbfill_idx;
   assign bus.o1_is_cnt      = slot_q[1].is_cnt;
   assign bus.o1_timer       = slot_q[1].timer;
   assign bus.o1_wen         = slot_q[1].wen;
   assign bus.o1_wdest       = slot_q[1].wdest;
   assign bus.o1_wdata       = slot_q[1].wdata;
   assign bus.o1_csr_rstat   = slot_q[1].csr_rstat;
   assign bus.o1_csr_data    = slot_q[1].csr_data;

   assign bus.oex_excp_valid    = ex_q.excp_valid;
   assign bus.oex_eret          = ex_q.eret;
   assign bus.oex_intrNo        = ex_q.intrno;
   assign bus.oex_cause         = ex_q.cause;
   assign bus.oex_exceptionPC   = ex_q.pc;
   assign bus.oex_exceptionInst = ex_q.inst;

   assign bus.ost_valid  = st_q.valid;
   assign bus.ost_paddr  = st_q.paddr;
   assign bus.ost_vaddr  = st_q.vaddr;
   assign bus.ost_data   = st_q.data;
   assign bus.old_valid  = ld_q.valid;
   assign bus.old_paddr  = ld_q.paddr;
   assign bus.old_vaddr  = ld_q.vaddr;
   assign bus.commit_cnt = commit_cnt_q;
   assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_diff_commit_stage.sv
// Self-checking bench for diff_commit_stage: directed cases then randomized traffic,
// each cycle compared against a queue-based model of the commit collection rules.
module tb_diff_commit_stage;
   localparam int unsigned T         = 8;
   localparam logic [31:0] MMIO_BASE = 32'hBF00_0000;
   localparam logic [31:0] MMIO_MASK = 32'hFF00_0000;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   diff_commit_stage_if bus ();

   diff_commit_stage #(.TIMEOUT_CYCLES(T), .MMIO_BASE(MMIO_BASE), .MMIO_MASK(MMIO_MASK)) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        valid;
      logic [31:0] pc, instr;
      logic        wen;
      logic [4:0]  wdest;
      logic [31:0] wdata;
      logic        mem_en;
      logic [31:0] paddr;
      logic        is_cnt, csr_rstat;
      logic [31:0] csr_data;
      logic        tlb;
      logic [4:0]  tlb_idx;
   } lane_s;

   typedef struct {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] instr;
      logic        skip, tlb;
      logic [4:0]  tlb_idx;
      logic        is_cnt;
      logic [63:0] timer;
      logic        wen;
      logic [7:0]  wdest;
      logic [63:0] wdata;
      logic        csr_rstat;
      logic [31:0] csr_data;
   } slot_s;

   // stimulus
   lane_s       lin [2];
   logic [63:0] stable;
   logic        ex_v, ex_e;
   logic [10:0] ex_int;
   logic [5:0]  ex_code;
   logic [31:0] ex_pc_i, ex_inst_i;
   logic [7:0]  st_v, ld_v;
   logic [31:0] st_p, st_va, st_d, ld_p, ld_va;

   // reference model state
   slot_s       e_slot [2];
   logic        e_exv, e_ere;
   logic [10:0] e_int;
   logic [5:0]  e_cause;
   logic [31:0] e_epc, e_einst;
   logic [7:0]  e_stv, e_ldv;
   logic [63:0] e_stp, e_stva, e_std, e_ldp, e_ldva;
   logic [63:0] e_cnt;
   int          idle_run;
   logic        e_to;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) lin[k] = '{default: '0};
      stable = '0; ex_v = 0; ex_e = 0; ex_int = '0; ex_code = '0; ex_pc_i = '0; ex_inst_i = '0;
      st_v = '0; st_p = '0; st_va = '0; st_d = '0; ld_v = '0; ld_p = '0; ld_va = '0;
   endtask

   task automatic randomize_inputs();
      for (int k = 0; k < 2; k++) begin
         lin[k].valid     = ($urandom % 3) != 0;
         lin[k].pc        = $urandom;
         lin[k].instr     = $urandom;
         lin[k].wen       = 1'($urandom);
         lin[k].wdest     = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
         lin[k].wdata     = $urandom;
         lin[k].mem_en    = 1'($urandom);
         lin[k].paddr     = ($urandom % 2 == 0) ? {8'hBF, 24'($urandom)} : $urandom;
         lin[k].is_cnt    = 1'($urandom);
         lin[k].csr_rstat = 1'($urandom);
         lin[k].csr_data  = $urandom;
         lin[k].tlb       = 1'($urandom);
         lin[k].tlb_idx   = 5'($urandom);
      end
      stable    = {$urandom, $urandom};
      ex_v      = ($urandom % 8) == 0;
      ex_e      = ($urandom % 8) == 0;
      ex_int    = 11'($urandom);
      ex_code   = 6'($urandom);
      ex_pc_i   = $urandom;
      ex_inst_i = $urandom;
      st_v      = ($urandom % 2 == 0) ? 8'($urandom) : 8'd0;
      ld_v      = ($urandom % 2 == 0) ? 8'($urandom) : 8'd0;
      st_p = $urandom; st_va = $urandom; st_d = $urandom; ld_p = $urandom; ld_va = $urandom;
   endtask

   task automatic apply();
      bus.c0_valid = lin[0].valid; bus.c0_pc = lin[0].pc; bus.c0_instr = lin[0].instr;
      bus.c0_wen = lin[0].wen; bus.c0_wdest = lin[0].wdest; bus.c0_wdata = lin[0].wdata;
      bus.c0_mem_en = lin[0].mem_en; bus.c0_mem_paddr = lin[0].paddr; bus.c0_is_cnt = lin[0].is_cnt;
      bus.c0_csr_rstat = lin[0].csr_rstat; bus.c0_csr_data = lin[0].csr_data;
      bus.c0_is_tlbfill = lin[0].tlb; bus.c0_tlbfill_idx = lin[0].tlb_idx;
      bus.c1_valid = lin[1].valid; bus.c1_pc = lin[1].pc; bus.c1_instr = lin[1].instr;
      bus.c1_wen = lin[1].wen; bus.c1_wdest = lin[1].wdest; bus.c1_wdata = lin[1].wdata;
      bus.c1_mem_en = lin[1].mem_en; bus.c1_mem_paddr = lin[1].paddr; bus.c1_is_cnt = lin[1].is_cnt;
      bus.c1_csr_rstat = lin[1].csr_rstat; bus.c1_csr_data = lin[1].csr_data;
      bus.c1_is_tlbfill = lin[1].tlb; bus.c1_tlbfill_idx = lin[1].tlb_idx;
      bus.stable_cnt = stable;
      bus.ex_valid = ex_v; bus.ex_eret = ex_e; bus.ex_intrno = ex_int; bus.ex_ecode = ex_code;
      bus.ex_pc = ex_pc_i; bus.ex_inst = ex_inst_i;
      bus.st_valid = st_v; bus.st_paddr = st_p; bus.st_vaddr = st_va; bus.st_data = st_d;
      bus.ld_valid = ld_v; bus.ld_paddr = ld_p; bus.ld_vaddr = ld_va;
   endtask

   task automatic reset_model();
      e_slot[0] = '{default: '0};
      e_slot[1] = '{default: '0};
      e_exv = 0; e_ere = 0; e_int = '0; e_cause = '0; e_epc = '0; e_einst = '0;
      e_stv = '0; e_stp = '0; e_stva = '0; e_std = '0; e_ldv = '0; e_ldp = '0; e_ldva = '0;
      e_cnt = '0; idle_run = 0; e_to = 0;
   endtask

   // Valid lanes are queued in lane order and dealt into slots; leftover slots are empty.
   task automatic predict();
      int q[$];
      for (int k = 0; k < 2; k++) if (lin[k].valid) q.push_back(k);
      for (int s = 0; s < 2; s++) begin
         e_slot[s] = '{default: '0};
         if (s < q.size()) begin
            lane_s l = lin[q[s]];
            e_slot[s].valid     = 1;
            e_slot[s].pc        = 64'(l.pc);
            e_slot[s].instr     = l.instr;
            e_slot[s].skip      = l.mem_en && ((l.paddr & MMIO_MASK) == MMIO_BASE);
            e_slot[s].tlb       = l.tlb;
            e_slot[s].tlb_idx   = l.tlb_idx;
            e_slot[s].is_cnt    = l.is_cnt;
            e_slot[s].timer     = l.is_cnt ? stable : 64'd0;
            e_slot[s].wen       = l.wen && (l.wdest != 0);
            e_slot[s].wdest     = 8'(l.wdest);
            e_slot[s].wdata     = 64'(l.wdata);
            e_slot[s].csr_rstat = l.csr_rstat;
            e_slot[s].csr_data  = l.csr_data;
         end
      end
      e_exv = ex_v; e_ere = ex_e;
      e_int = (ex_v || ex_e) ? ex_int : '0;
      e_cause = (ex_v || ex_e) ? ex_code : '0;
      e_epc = (ex_v || ex_e) ? ex_pc_i : '0;
      e_einst = (ex_v || ex_e) ? ex_inst_i : '0;
      e_stv = st_v;
      e_stp = (st_v != 0) ? 64'(st_p) : '0;
      e_stva = (st_v != 0) ? 64'(st_va) : '0;
      e_std = (st_v != 0) ? 64'(st_d) : '0;
      e_ldv = ld_v;
      e_ldp = (ld_v != 0) ? 64'(ld_p) : '0;
      e_ldva = (ld_v != 0) ? 64'(ld_va) : '0;
      e_cnt = e_cnt + 64'(q.size());
      if (q.size() == 0 && !ex_v && !ex_e) idle_run++;
      else idle_run = 0;
      if (idle_run >= T) e_to = 1;
   endtask

   function automatic slot_s obs_slot(input int s);
      slot_s o;
      if (s == 0) o = '{bus.o0_valid, bus.o0_pc, bus.o0_instr, bus.o0_skip, bus.o0_is_tlbfill,
                        bus.o0_tlbfill_idx, bus.o0_is_cnt, bus.o0_timer, bus.o0_wen, bus.o0_wdest,
                        bus.o0_wdata, bus.o0_csr_rstat, bus.o0_csr_data};
      else        o = '{bus.o1_valid, bus.o1_pc, bus.o1_instr, bus.o1_skip, bus.o1_is_tlbfill,
                        bus.o1_tlbfill_idx, bus.o1_is_cnt, bus.o1_timer, bus.o1_wen, bus.o1_wdest,
                        bus.o1_wdata, bus.o1_csr_rstat, bus.o1_csr_data};
      return o;
   endfunction

   task automatic compare();
      for (int s = 0; s < 2; s++) begin
         slot_s o = obs_slot(s);
         check($sformatf("o%0d_valid", s), o.valid, e_slot[s].valid);
         check($sformatf("o%0d_pc", s), o.pc, e_slot[s].pc);
         check($sformatf("o%0d_instr", s), o.instr, e_slot[s].instr);
         check($sformatf("o%0d_skip", s), o.skip, e_slot[s].skip);
         check($sformatf("o%0d_is_tlbfill", s), o.tlb, e_slot[s].tlb);
         check($sformatf("o%0d_tlbfill_idx", s), o.tlb_idx, e_slot[s].tlb_idx);
         check($sformatf("o%0d_is_cnt", s), o.is_cnt, e_slot[s].is_cnt);
         check($sformatf("o%0d_timer", s), o.timer, e_slot[s].timer);
         check($sformatf("o%0d_wen", s), o.wen, e_slot[s].wen);
         check($sformatf("o%0d_wdest", s), o.wdest, e_slot[s].wdest);
         check($sformatf("o%0d_wdata", s), o.wdata, e_slot[s].wdata);
         check($sformatf("o%0d_csr_rstat", s), o.csr_rstat, e_slot[s].csr_rstat);
         check($sformatf("o%0d_csr_data", s), o.csr_data, e_slot[s].csr_data);
      end
      check("oex_excp_valid", bus.oex_excp_valid, e_exv);
      check("oex_eret", bus.oex_eret, e_ere);
      check("oex_intrNo", bus.oex_intrNo, e_int);
      check("oex_cause", bus.oex_cause, e_cause);
      check("oex_exceptionPC", bus.oex_exceptionPC, e_epc);
      check("oex_exceptionInst", bus.oex_exceptionInst, e_einst);
      check("ost_valid", bus.ost_valid, e_stv);
      check("ost_paddr", bus.ost_paddr, e_stp);
      check("ost_vaddr", bus.ost_vaddr, e_stva);
      check("ost_data", bus.ost_data, e_std);
      check("old_valid", bus.old_valid, e_ldv);
      check("old_paddr", bus.old_paddr, e_ldp);
      check("old_vaddr", bus.old_vaddr, e_ldva);
      check("commit_cnt", bus.commit_cnt, e_cnt);
      check("timeout", bus.timeout, e_to);
   endtask

   // Drive current stimulus, advance one edge, compare one step after the edge.
   task automatic step();
      apply();
      predict();
      @(posedge clock);
      #1;
      compare();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: simulation still running at %0t", $time);
      $fatal(1, "time limit");
   end

   initial begin
      clear_inputs();
      apply();
      reset_model();
      repeat (3) @(posedge clock);
      #1;
      compare();
      resetn = 1'b1;

      clear_inputs();
      lin[0].valid = 1; lin[0].pc = 32'h1c00_0000; lin[0].wen = 1; lin[0].wdest = 5'd4;
      lin[0].wdata = 32'hDEAD_BEEF;
      step();

      clear_inputs();
      lin[1].valid = 1; lin[1].pc = 32'h1c00_0010; lin[1].instr = 32'h0280_0421;
      step();

      clear_inputs();
      lin[0].valid = 1; lin[0].pc = 32'h1c00_0020;
      lin[1].valid = 1; lin[1].pc = 32'h1c00_0024;
      step();

      clear_inputs();
      lin[0].valid = 1; lin[0].wen = 1; lin[0].wdest = 5'd0; lin[0].wdata = 32'h1234_5678;
      step();

      clear_inputs();
      lin[0].valid = 1; lin[0].mem_en = 1; lin[0].paddr = 32'hBF00_03F8;
      step();
      lin[0].paddr = 32'h1C00_1000;
      step();

      clear_inputs();
      lin[0].valid = 1; lin[0].is_cnt = 1; stable = 64'h123;
      step();
      lin[0].is_cnt = 0;
      step();

      clear_inputs();
      ex_v = 1; ex_code = 6'h0B; ex_pc_i = 32'h1c00_0100; ex_inst_i = 32'h002b_0000;
      lin[0].valid = 1; lin[0].pc = 32'h1c00_00fc;
      step();
      clear_inputs();
      step();

      repeat (10) begin
         clear_inputs();
         step();
      end
      clear_inputs();
      lin[0].valid = 1; lin[1].valid = 1;
      repeat (3) step();

      clear_inputs();
      lin[0].valid = 1; lin[0].pc = 32'h1c00_0200;
      step();
      resetn = 1'b0;
      #1;
      reset_model();
      compare();
      repeat (2) @(posedge clock);
      #1;
      compare();
      clear_inputs();
      resetn = 1'b1;
      step();

      repeat (300) begin
         randomize_inputs();
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
